// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a small TX FIFO.
// The CPU writes bytes through TXDATA. Each byte goes out on txd as an
// 8N1 frame, with the bit period taken from DIVISOR.
// STATUS and DIVISOR can be polled through a combinational read path.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1).
module uart_tx_mmio #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        txd
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic wr_txdata;
   logic wr_status;
   logic wr_divisor;
   logic ovf_clear;

   assign wr_txdata  = ce & we & sel[0] & (addr[3:2] == REG_TXDATA);
   assign wr_status  = ce & we & sel[0] & (addr[3:2] == REG_STATUS);
   assign wr_divisor = ce & we & (addr[3:2] == REG_DIVISOR);
   assign ovf_clear  = wr_status & data_i[3];

   // Only addr[3:2] is decoded. The upper data lanes are never stored.
   logic unused_bits;
   assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

   // ------------------------------------------------------------------
   // State declarations
   // ------------------------------------------------------------------
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      div_q, div_d;

   state_t           state_q;
   logic [7:0]       shift_q;
   logic [15:0]      baud_q;
   logic [2:0]       bit_q;
   logic             txd_q;
`ifdef UART_TX_PARITY_EN
   logic             parity_q;
`endif

   logic             full;
   logic             empty;
   logic             pop;
   logic             push_ok;
   logic [15:0]      div_m1;
   logic [7:0]       head;

   assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // The transmitter takes the head byte in the IDLE->START cycle. That free
   // slot lets a push into a full FIFO in the same cycle still be accepted.
   assign pop     = (state_q == ST_IDLE) && !empty;
   assign push_ok = wr_txdata && (!full || pop);

   // Reload value for the baud counter. A DIVISOR of 0 behaves like 1.
   assign div_m1 = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

   // ------------------------------------------------------------------
   // FIFO / overflow / divisor next-state
   // ------------------------------------------------------------------
   // Compute the pointer, count, overflow and divisor updates for this cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      div_d    = div_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // A clear and a new overflow in the same cycle leave the flag set.
      if (ovf_clear) begin
         ovf_d = 1'b0;
      end
      if (wr_txdata && full && !pop) begin
         ovf_d = 1'b1;
      end

      if (wr_divisor && sel[0]) begin
         div_d[7:0] = data_i[7:0];
      end
      if (wr_divisor && sel[1]) begin
         div_d[15:8] = data_i[15:8];
      end
   end

   // Register the FIFO control, the sticky overflow flag and DIVISOR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DIV_RESET;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
      end
   end

   // Store accepted bytes. The storage holds only data, so it is not reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   // Run the frame sequencer. txd_q is loaded with the level of the segment
   // being entered, so the line is registered and changes only at edges.
   // The baud counter is reloaded from DIVISOR at each bit boundary, so a
   // DIVISOR write never stretches or shortens the bit already in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q  <= head;
                  baud_q   <= div_m1;
                  state_q  <= ST_START;
                  txd_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^head;
`endif
               end
            end

            ST_START: begin
               if (baud_q == 16'd0) begin
                  baud_q  <= div_m1;
                  bit_q   <= 3'd0;
                  state_q <= ST_DATA;
                  txd_q   <= shift_q[0];
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end

            ST_DATA: begin
               if (baud_q == 16'd0) begin
                  baud_q <= div_m1;
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= ST_PARITY;
                     txd_q   <= parity_q;
`else
                     state_q <= ST_STOP;
                     txd_q   <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_q == 16'd0) begin
                  baud_q  <= div_m1;
                  state_q <= ST_STOP;
                  txd_q   <= 1'b1;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
`endif

            ST_STOP: begin
               txd_q <= 1'b1;
               if (baud_q == 16'd0) begin
                  state_q <= ST_IDLE;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end

   assign txd = txd_q;

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   logic [31:0] status;
   logic [4:0]  cnt5;

   assign cnt5   = 5'(cnt_q);
   assign status = {23'd0, cnt5, ovf_q, empty, full, (state_q != ST_IDLE)};

   // Return register contents combinationally. Reads have no side effects.
   always_comb begin
      data_o = 32'h0;
      if (ce && !we) begin
         case (addr[3:2])
            REG_STATUS:  data_o = status;
            REG_DIVISOR: data_o = {16'h0, div_q};
            default:     data_o = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: self-checking bench for uart_tx_mmio.
// The frame monitor decodes txd as a UART line.
// The FIFO reference predicts byte acceptance from arrival and departure times.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        txd;

   uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .we     (we),
      .addr   (addr),
      .sel    (sel),
      .data_i (data_i),
      .data_o (data_o),
      .txd    (txd)
   );

   always #5 clk = ~clk;

   // Rising-edge count. At a falling edge it equals the number of the previous rising edge.
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_q[$];
   longint     pend[$];
   longint     last_pop = -100000;
   logic       m_ovf = 1'b0;
   int         accepted = 0;
   int         mon_div = 434;
   bit         mon_en = 1'b1;
   int         rx_frames = 0;

   typedef struct packed {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line levels of a frame: start, 8 data bits LSB first, optional parity, stop.
   function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, 1'b1, b, 1'b0};
`endif
   endfunction

   // Reference FIFO. A byte leaves the FIFO one clock after its arrival, or one
   // clock after the previous frame finishes, whichever is later. A byte is
   // dropped when DEPTH bytes are still waiting and none leaves on that edge.
   task automatic model_push(input longint e, input logic [7:0] b);
      longint p;
      longint f;
      while (pend.size() > 0 && pend[0] < e) void'(pend.pop_front());
      if (pend.size() == DEPTH && pend[0] != e) begin
         m_ovf = 1'b1;
      end else begin
         f = longint'(NB) * longint'((mon_div < 1) ? 1 : mon_div);
         p = (e + 1 > last_pop + f + 1) ? e + 1 : last_pop + f + 1;
         last_pop = p;
         pend.push_back(p);
         exp_q.push_back(b);
         accepted++;
      end
   endtask

   // UART line monitor. Every frame must match the next byte the reference sent.
   initial begin : monitor
      logic [10:0] pat;
      logic [7:0]  b;
      int          d;
      int          bad_clk;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && txd === 1'b0) begin
            d = (mon_div < 1) ? 1 : mon_div;
            check("frame_was_queued", 32'(exp_q.size() != 0), 32'd1);
            b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            pat = frame_bits(b);
            for (int bi = 0; bi < NB; bi++) begin
               bad_clk = 0;
               for (int c = 0; c < d; c++) begin
                  if (!(bi == 0 && c == 0)) @(negedge clk);
                  if (txd !== pat[bi]) bad_clk++;
               end
               check($sformatf("frame_%02h_bit%0d_bad_clocks", b, bi), bad_clk, 0);
            end
            rx_frames++;
            @(negedge clk);
            check("idle_gap", txd, 1'b1);
         end
      end
   end

   task automatic bus_idle();
      ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = a; sel = s; data_i = d;
      if (a[3:2] == 2'd1 && s[0] && d[3]) m_ovf = 1'b0;
      if (a[3:2] == 2'd0 && s[0] && mon_en) model_push(cyc + 1, d[7:0]);
      @(posedge clk);
      #1 bus_idle();
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF; data_i = 32'h0;
      #1 check(name, data_o, exp);
      bus_idle();
   endtask

   task automatic set_div(input int d);
      do_write(32'h8, 4'b0011, 32'(d));
      mon_div = d;
   endtask

   task automatic wait_drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 5000 && !ok; n++) begin
         @(negedge clk);
         ce = 1'b1; we = 1'b0; addr = 32'h4; sel = 4'hF;
         #1 if ((data_o & ~32'h8) == 32'h4) ok = 1'b1;
      end
      bus_idle();
      check({name, "_drained"}, 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      check({name, "_all_sent"}, exp_q.size(), 0);
   endtask

   vec_t vt [21];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : main
      int rx0;
      int acc0;
      int busy_n;
      int zeros;
      int idx;
      int cnt;
      int d;
      logic [7:0] b;
      logic       samp [40];
      logic [10:0] pat;

      bus_idle();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("txd_in_reset", txd, 1'b1);
      rst = 1'b0;

      // Register access table: {ce, we, addr, sel, wdata, expected data_o}
      vt[0]  = '{1'b1, 1'b0, 32'h4,        4'hF,    32'h0,        32'h4};
      vt[1]  = '{1'b1, 1'b0, 32'h8,        4'hF,    32'h0,        32'h1B2};
      vt[2]  = '{1'b1, 1'b0, 32'h0,        4'hF,    32'h0,        32'h0};
      vt[3]  = '{1'b1, 1'b0, 32'hC,        4'hF,    32'h0,        32'h0};
      vt[4]  = '{1'b0, 1'b0, 32'h4,        4'hF,    32'h0,        32'h0};
      vt[5]  = '{1'b1, 1'b1, 32'h4,        4'hF,    32'h0,        32'h0};
      vt[6]  = '{1'b1, 1'b1, 32'h0,        4'b0010, 32'hFF,       32'h0};
      vt[7]  = '{1'b1, 1'b0, 32'h4,        4'hF,    32'h0,        32'h4};
      vt[8]  = '{1'b1, 1'b1, 32'hC,        4'hF,    32'hFFFFFFFF, 32'h0};
      vt[9]  = '{1'b1, 1'b0, 32'h10000008, 4'hF,    32'h0,        32'h1B2};
      vt[10] = '{1'b1, 1'b1, 32'h8,        4'b0001, 32'hFFFFFF07, 32'h0};
      vt[11] = '{1'b1, 1'b0, 32'h8,        4'hF,    32'h0,        32'h107};
      vt[12] = '{1'b1, 1'b1, 32'h8,        4'b0010, 32'hFFFF03FF, 32'h0};
      vt[13] = '{1'b1, 1'b0, 32'h8,        4'hF,    32'h0,        32'h307};
      vt[14] = '{1'b1, 1'b1, 32'h8,        4'b1100, 32'hFFFFFFFF, 32'h0};
      vt[15] = '{1'b1, 1'b0, 32'hA,        4'hF,    32'h0,        32'h307};
      vt[16] = '{1'b1, 1'b0, 32'h6,        4'hF,    32'h0,        32'h4};
      vt[17] = '{1'b0, 1'b1, 32'h8,        4'b0011, 32'h0,        32'h0};
      vt[18] = '{1'b1, 1'b0, 32'h8,        4'hF,    32'h0,        32'h307};
      vt[19] = '{1'b1, 1'b1, 32'h0,        4'b0000, 32'h55,       32'h0};
      vt[20] = '{1'b1, 1'b0, 32'h4,        4'hF,    32'h0,        32'h4};
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         ce = vt[i].ce; we = vt[i].we; addr = vt[i].addr; sel = vt[i].sel; data_i = vt[i].wdata;
         #1 check($sformatf("vec%0d", i), data_o, vt[i].exp);
      end
      @(negedge clk);
      bus_idle();
      check("txd_idle_after_table", txd, 1'b1);

      // One A5 frame at 4 clocks per bit. busy must cover exactly the frame.
      set_div(4);
      rx0 = rx_frames;
      do_write(32'h0, 4'b0001, 32'hA5);
      do_read(32'h4, 32'h10, "a5_queued_status");
      busy_n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         ce = 1'b1; we = 1'b0; addr = 32'h4; sel = 4'hF;
         #1 if (data_o[0]) busy_n++;
      end
      bus_idle();
      check("a5_busy_clocks", busy_n, NB * 4);
      wait_drain("a5");
      check("a5_frames", rx_frames - rx0, 1);

      // Burst of 6 writes into a 4-deep FIFO. Five bytes go out and one is dropped.
      set_div(2);
      rx0 = rx_frames;
      for (int i = 0; i < 6; i++) do_write(32'h0, 4'b0001, 32'($urandom));
      do_read(32'h4, 32'h4B, "burst_status");
      check("burst_ref_ovf", m_ovf, 1'b1);
      do_write(32'h4, 4'b0001, 32'h8);
      do_read(32'h4, 32'h43, "ovf_cleared_status");
      wait_drain("burst");
      check("burst_frames", rx_frames - rx0, 5);

      // DIVISOR 0 gives 1-clock bits. A change to 3 mid-frame applies from the next bit.
      mon_en = 1'b0;
      do_write(32'h8, 4'b0011, 32'h0);
      do_read(32'h8, 32'h0, "div_zero_readback");
      b = 8'h96;
      do_write(32'h0, 4'b0001, 32'(b));
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         samp[i] = txd;
         if (i == 2) begin
            ce = 1'b1; we = 1'b1; addr = 32'h8; sel = 4'b0011; data_i = 32'h3;
         end else begin
            bus_idle();
         end
      end
      check("div0_idle_before", samp[0], 1'b1);
      pat = frame_bits(b);
      idx = 1;
      for (int bi = 0; bi < NB; bi++) begin
         d = (bi < 3) ? 1 : 3;
         zeros = 0;
         for (int c = 0; c < d; c++) begin
            if (samp[idx] !== pat[bi]) zeros++;
            idx++;
         end
         check($sformatf("div_change_bit%0d_bad_clocks", bi), zeros, 0);
      end
      zeros = 0;
      for (int i = idx; i < 40; i++) if (samp[i] !== 1'b1) zeros++;
      check("div_change_idle_after", zeros, 0);
      mon_div = 3;
      mon_en = 1'b1;
      wait_drain("divchg");

      // Random traffic against the reference FIFO
      for (int r = 0; r < 2; r++) begin
         set_div($urandom_range(1, 3));
         rx0 = rx_frames;
         acc0 = accepted;
         for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            do_write(32'h0, 4'b0001, 32'($urandom));
            @(negedge clk);
            ce = 1'b1; we = 1'b0; addr = 32'h4; sel = 4'hF;
            cnt = 0;
            foreach (pend[k]) if (pend[k] > cyc) cnt++;
            #1 check($sformatf("rand%0d_status%0d", r, i), 32'(data_o[8:3]),
                     32'({5'(cnt), m_ovf}));
            bus_idle();
         end
         wait_drain("rand");
         check("rand_frames", rx_frames - rx0, accepted - acc0);
         do_write(32'h4, 4'b0001, 32'h8);
      end

      // Reset during the data bits of 3C drops the frame at once.
      mon_en = 1'b0;
      set_div(4);
      do_write(32'h0, 4'b0001, 32'h3C);
      repeat (6) @(negedge clk);
      check("pre_reset_txd_data_bit", txd, 1'b0);
      rst = 1'b1;
      #1 check("reset_txd_async", txd, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pend.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      do_read(32'h4, 32'h4, "post_reset_status");
      do_read(32'h8, 32'h1B2, "post_reset_divisor");
      zeros = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) zeros++;
      end
      check("no_residual_frame", zeros, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
